// File: rtl/dsp_mem_arbiter_pkg.sv
// Shared definitions for the DSP / sample-DMA SRAM bank II arbiter.
// Contents:
//   SRAM_ADDR_LEN, REG_WORD_LEN : default address and data widths
//   ST_ARB, ST_DMA_LOCK         : FSM state encoding (arb_state_t)
//   OWNER_DSP, OWNER_DMA        : encoding of the last_owner register
//   arb_dbg_t                   : debug view of the arbiter's internal state
package dsp_mem_arbiter_pkg;

    localparam int SRAM_ADDR_LEN = 10;
    localparam int REG_WORD_LEN  = 32;

    localparam logic ST_ARB      = 1'b0;
    localparam logic ST_DMA_LOCK = 1'b1;

    typedef enum logic {
        ARB      = ST_ARB,
        DMA_LOCK = ST_DMA_LOCK
    } arb_state_t;

    localparam logic OWNER_DSP = 1'b0;
    localparam logic OWNER_DMA = 1'b1;

    typedef struct packed {
        arb_state_t  state;
        logic        last_owner;
        logic [7:0]  beat_cnt;
    } arb_dbg_t;

endpackage

// File: rtl/dsp_mem_arbiter_if.sv
// Bus bundle between the DSP core, the sample DMA, the SRAM bank and the
// arbiter.
//   slave  modport : the arbiter's view (requests in, grants/SRAM out)
//   master modport : the requesters' and SRAM's view
// Handshake: a requester raises *_req with a stable command; the access
// happens in any cycle where its grant is high (DSP: dsp_stall low, DMA:
// dma_gnt high). A read's data returns exactly one cycle later, qualified
// by a single-cycle *_rvalid pulse; writes return nothing.
interface dsp_mem_arbiter_if
    import dsp_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = SRAM_ADDR_LEN,
    parameter int DATA_W = REG_WORD_LEN
);
    logic              dsp_req;
    logic              dsp_we;
    logic [ADDR_W-1:0] dsp_addr;
    logic [DATA_W-1:0] dsp_wdata;
    logic              dsp_stall;
    logic [DATA_W-1:0] dsp_rdata;
    logic              dsp_rvalid;

    logic              dma_req;
    logic              dma_we;
    logic [ADDR_W-1:0] dma_addr;
    logic [DATA_W-1:0] dma_wdata;
    logic              dma_last;
    logic              dma_gnt;
    logic [DATA_W-1:0] dma_rdata;
    logic              dma_rvalid;

    logic              sram_en;
    logic              sram_we;
    logic [ADDR_W-1:0] sram_addr;
    logic [DATA_W-1:0] sram_wdata;
    logic [DATA_W-1:0] sram_rdata;

    modport slave (
        input  dsp_req, dsp_we, dsp_addr, dsp_wdata,
        output dsp_stall, dsp_rdata, dsp_rvalid,
        input  dma_req, dma_we, dma_addr, dma_wdata, dma_last,
        output dma_gnt, dma_rdata, dma_rvalid,
        output sram_en, sram_we, sram_addr, sram_wdata,
        input  sram_rdata
    );

    modport master (
        output dsp_req, dsp_we, dsp_addr, dsp_wdata,
        input  dsp_stall, dsp_rdata, dsp_rvalid,
        output dma_req, dma_we, dma_addr, dma_wdata, dma_last,
        input  dma_gnt, dma_rdata, dma_rvalid,
        input  sram_en, sram_we, sram_addr, sram_wdata,
        output sram_rdata
    );

endinterface

// File: rtl/dsp_mem_arbiter_rr_pick2.sv
// Combinational two-way round-robin winner select.
// Ports:
//   req_a, req_b : requests
//   last_b       : 1 when b owned the previous access (a wins a tie)
//   gnt_a, gnt_b : one-hot-or-zero grants
module rr_pick2 (
    input  logic req_a,
    input  logic req_b,
    input  logic last_b,
    output logic gnt_a,
    output logic gnt_b
);
    assign gnt_a = req_a & (~req_b |  last_b);
    assign gnt_b = req_b & (~req_a | ~last_b);
endmodule

// File: rtl/dsp_mem_arbiter.sv
// Arbiter between the DSP core (single accesses) and the sample DMA
// (bursts) for SRAM bank II. Outside a burst the two alternate; once the
// DMA starts a multi-beat burst it keeps the bank for up to BURST_MAX
// beats, which bounds the DSP's wait to BURST_MAX cycles.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   bus      : dsp_mem_arbiter_if.slave (DSP, DMA and SRAM signals)
//   dbg      : state, last_owner and beat_cnt for observation
module dsp_mem_arbiter
    import dsp_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W    = SRAM_ADDR_LEN,
    parameter int DATA_W    = REG_WORD_LEN,
    parameter int BURST_MAX = 8
)(
    input  logic                     clk,
    input  logic                     rst,
    dsp_mem_arbiter_if.slave         bus,
    output arb_dbg_t                 dbg
);
    localparam logic [ADDR_W-1:0] ADDR_ZERO   = '0;
    localparam logic [DATA_W-1:0] DATA_ZERO   = '0;
    localparam logic [7:0]        BURST_MAX_B = 8'(BURST_MAX);

    arb_state_t state;
    logic       last_owner;
    logic [7:0] beat_cnt;
    logic [7:0] beat_next;
    logic       rd_dsp;     // read-owner tag: DSP read last cycle
    logic       rd_dma;     // read-owner tag: DMA read last cycle

    logic pick_dsp, pick_dma;
    logic dsp_grant, dma_grant;

    rr_pick2 u_pick (
        .req_a  (bus.dsp_req),
        .req_b  (bus.dma_req),
        .last_b (last_owner == OWNER_DMA),
        .gnt_a  (pick_dsp),
        .gnt_b  (pick_dma)
    );

    // Grants are combinational from registered state and live requests.
    // During a lock the DMA alone may use the bank.
    always_comb begin
        dsp_grant = 1'b0;
        dma_grant = 1'b0;
        if (!rst) begin
            if (state == ARB) begin
                dsp_grant = pick_dsp;
                dma_grant = pick_dma;
            end else begin
                dma_grant = bus.dma_req;
            end
        end
    end

    always_comb begin
        bus.sram_en    = 1'b0;
        bus.sram_we    = 1'b0;
        bus.sram_addr  = ADDR_ZERO;
        bus.sram_wdata = DATA_ZERO;
        if (dsp_grant) begin
            bus.sram_en    = 1'b1;
            bus.sram_we    = bus.dsp_we;
            bus.sram_addr  = bus.dsp_addr;
            bus.sram_wdata = bus.dsp_wdata;
        end else if (dma_grant) begin
            bus.sram_en    = 1'b1;
            bus.sram_we    = bus.dma_we;
            bus.sram_addr  = bus.dma_addr;
            bus.sram_wdata = bus.dma_wdata;
        end
    end

    assign bus.dsp_stall  = bus.dsp_req & ~dsp_grant;
    assign bus.dma_gnt    = dma_grant;
    assign bus.dsp_rvalid = rd_dsp;
    assign bus.dma_rvalid = rd_dma;
    assign bus.dsp_rdata  = rd_dsp ? bus.sram_rdata : DATA_ZERO;
    assign bus.dma_rdata  = rd_dma ? bus.sram_rdata : DATA_ZERO;

    assign beat_next = beat_cnt + 8'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ARB;
            last_owner <= OWNER_DMA;
            beat_cnt   <= 8'd0;
            rd_dsp     <= 1'b0;
            rd_dma     <= 1'b0;
        end else begin
            rd_dsp <= dsp_grant & ~bus.dsp_we;
            rd_dma <= dma_grant & ~bus.dma_we;
            case (state)
                ARB: begin
                    if (dsp_grant) begin
                        last_owner <= OWNER_DSP;
                    end else if (dma_grant) begin
                        if (bus.dma_last || BURST_MAX == 1) begin
                            last_owner <= OWNER_DMA;
                        end else begin
                            state    <= DMA_LOCK;
                            beat_cnt <= 8'd1;
                        end
                    end
                end
                DMA_LOCK: begin
                    // A request gap ends the lock without an access.
                    if (!bus.dma_req || bus.dma_last || beat_next == BURST_MAX_B) begin
                        state      <= ARB;
                        last_owner <= OWNER_DMA;
                        beat_cnt   <= 8'd0;
                    end else begin
                        beat_cnt <= beat_next;
                    end
                end
                default: state <= ARB;
            endcase
        end
    end

    assign dbg = '{state: state, last_owner: last_owner, beat_cnt: beat_cnt};

endmodule
